// File: rtl/mtr_drv_pkg.sv
// rtl/mtr_drv_pkg.sv - shared widths, types and duty helpers for the motor PWM driver
package mtr_drv_pkg;

  localparam int PWM_W         = 11;
  localparam int SPD_W         = 11;
  localparam int DEAD_TIME_DEF = 32;
  localparam int RAMP_STEP_DEF = 64;

  typedef logic [PWM_W-1:0]        duty_t;
  typedef logic signed [SPD_W-1:0] spd_t;

  // Zero speed sits at mid-scale, i.e. 50% duty.
  localparam duty_t DUTY_MID = 11'h400;

  // Signed speed to unsigned duty: adding mid-scale modulo 2**PWM_W flips the sign bit.
  function automatic duty_t spd_to_duty(input spd_t s);
    return duty_t'(s) + DUTY_MID;
  endfunction

  // Step cur toward tgt by at most step, landing exactly on tgt when close enough.
  function automatic duty_t ramp_toward(input duty_t cur, input duty_t tgt, input duty_t step);
    if (tgt > cur) begin
      return ((tgt - cur) > step) ? (cur + step) : tgt;
    end else begin
      return ((cur - tgt) > step) ? (cur - step) : tgt;
    end
  endfunction

endpackage

// File: rtl/mtr_nonoverlap.sv
// rtl/mtr_nonoverlap.sv - complementary output pair with dead-time blanking for one wheel
module mtr_nonoverlap
  import mtr_drv_pkg::*;
#(
  parameter int DEAD_TIME = DEAD_TIME_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pwm_raw,
  output logic o_pwm1,
  output logic o_pwm2
);

  localparam int DW = $clog2(DEAD_TIME + 1);

  logic          r_prev;
  logic [DW-1:0] r_dead;
  logic          r_pwm1;
  logic          r_pwm2;
  logic          w_chg;

  assign w_chg = (i_pwm_raw != r_prev);

  // r_dead counts the blanking clocks still owed; at 1 the pair re-enables on this edge,
  // so both outputs sit low for exactly DEAD_TIME clocks after each raw edge is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_dead <= '0;
      r_pwm1 <= 1'b0;
      r_pwm2 <= 1'b0;
    end else begin
      r_prev <= i_pwm_raw;
      if (w_chg) begin
        r_dead <= DW'(DEAD_TIME);
        r_pwm1 <= 1'b0;
        r_pwm2 <= 1'b0;
      end else if (r_dead > DW'(1)) begin
        r_dead <= r_dead - DW'(1);
        r_pwm1 <= 1'b0;
        r_pwm2 <= 1'b0;
      end else begin
        r_dead <= '0;
        r_pwm1 <= i_pwm_raw;
        r_pwm2 <= ~i_pwm_raw;
      end
    end
  end

  assign o_pwm1 = r_pwm1;
  assign o_pwm2 = r_pwm2;

endmodule

// File: rtl/mtr_drv.sv
// rtl/mtr_drv.sv - dual-wheel PWM driver with period-latched duty (optional ramp: MTR_DRV_RAMP_EN)
module mtr_drv
  import mtr_drv_pkg::*;
#(
  parameter int DEAD_TIME = DEAD_TIME_DEF
`ifdef MTR_DRV_RAMP_EN
  , parameter int RAMP_STEP = RAMP_STEP_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [SPD_W-1:0] lft_spd,
  input  logic signed [SPD_W-1:0] rght_spd,
  output logic                    lftPWM1,
  output logic                    lftPWM2,
  output logic                    rghtPWM1,
  output logic                    rghtPWM2
);

  duty_t r_cnt;
  duty_t r_lft_duty;
  duty_t r_rght_duty;
  logic  r_lft_raw;
  logic  r_rght_raw;

  duty_t w_lft_tgt;
  duty_t w_rght_tgt;
  duty_t w_lft_next;
  duty_t w_rght_next;
  logic  w_latch;

  assign w_lft_tgt  = spd_to_duty(lft_spd);
  assign w_rght_tgt = spd_to_duty(rght_spd);
  assign w_latch    = (r_cnt == '1);

`ifdef MTR_DRV_RAMP_EN
  assign w_lft_next  = ramp_toward(r_lft_duty,  w_lft_tgt,  duty_t'(RAMP_STEP));
  assign w_rght_next = ramp_toward(r_rght_duty, w_rght_tgt, duty_t'(RAMP_STEP));
`else
  assign w_lft_next  = w_lft_tgt;
  assign w_rght_next = w_rght_tgt;
`endif

  // Shared free-running period counter, wraps naturally at 2**PWM_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + duty_t'(1);
    end
  end

  // Duty only changes on the last count so each period is built from one stable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft_duty  <= DUTY_MID;
      r_rght_duty <= DUTY_MID;
    end else if (w_latch) begin
      r_lft_duty  <= w_lft_next;
      r_rght_duty <= w_rght_next;
    end
  end

  // Registered compare; duty 0 never fires and cnt 2047 never fires, giving the 1-clk dip at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft_raw  <= 1'b0;
      r_rght_raw <= 1'b0;
    end else begin
      r_lft_raw  <= (r_cnt < r_lft_duty);
      r_rght_raw <= (r_cnt < r_rght_duty);
    end
  end

  mtr_nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_lft_no (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_pwm_raw (r_lft_raw),
    .o_pwm1    (lftPWM1),
    .o_pwm2    (lftPWM2)
  );

  mtr_nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_rght_no (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_pwm_raw (r_rght_raw),
    .o_pwm1    (rghtPWM1),
    .o_pwm2    (rghtPWM2)
  );

endmodule
